// File: rtl/deconcatenate.sv
// Unpacks frame words (nibble pairs -> byte) and replicated words (2-bit code); counts malformed words.
// Latency: one cycle from the accept of the completing word to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output freezes state, nibble and counter.
module deconcatenate #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_kind,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             half_pending
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_hi;
    logic [3:0]       w_hi_nxt;
    logic [7:0]       r_out_data;
    logic             r_out_tag;
    logic             r_out_vld;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_accept;
    logic             w_frame_ok;
    logic             w_rep_ok;
    logic [3:0]       w_nibble;
    logic [1:0]       w_code;
    logic             w_load;
    logic [7:0]       w_load_data;
    logic             w_load_tag;
    logic             w_err;

    // A slot is free when the output is empty or being drained this cycle.
    assign in_ready     = !r_out_vld || out_ready;
    assign w_accept     = in_valid && in_ready;

    // Format checks for both packing styles.
    assign w_frame_ok   = (in_data[15:6] == 10'd0) && (in_data[1:0] == 2'b11);
    assign w_rep_ok     = (in_data == {8{in_data[1:0]}});
    assign w_nibble     = in_data[5:2];
    assign w_code       = in_data[1:0];

    assign out_data     = r_out_data;
    assign out_tag      = r_out_tag;
    assign out_valid    = r_out_vld;
    assign err_pulse    = r_err_pulse;
    assign err_cnt      = r_err_cnt;
    assign half_pending = (r_state == S_HALF);

    // Next-state, nibble store, output load and error decisions for an accepted word.
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_load      = 1'b0;
        w_load_data = 8'd0;
        w_load_tag  = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            if (!in_kind) begin
                if (!w_frame_ok) begin
                    w_err = 1'b1;
                end else if (r_state == S_EMPTY) begin
                    w_hi_nxt    = w_nibble;
                    w_state_nxt = S_HALF;
                end else begin
                    w_load      = 1'b1;
                    w_load_data = {r_hi, w_nibble};
                    w_state_nxt = S_EMPTY;
                end
            end else begin
                if (!w_rep_ok) begin
                    w_err = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_load_data = {6'd0, w_code};
                    w_load_tag  = 1'b1;
                    // A code arriving mid-byte orphans the stored nibble.
                    if (r_state == S_HALF) begin
                        w_err       = 1'b1;
                        w_hi_nxt    = 4'd0;
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
        end
    end

    // State register and stored high nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_hi    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
        end
    end

    // Output register: a load wins over a consume, otherwise a consume empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= 8'd0;
            r_out_tag  <= 1'b0;
        end else if (w_load) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_load_data;
            r_out_tag  <= w_load_tag;
        end else if (r_out_vld && out_ready) begin
            r_out_vld  <= 1'b0;
            r_out_data <= 8'd0;
            r_out_tag  <= 1'b0;
        end
    end

    // Registered error pulse and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_deconcatenate.sv
module tb_deconcatenate;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_kind;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_tag;
    logic        out_valid;
    logic        out_ready;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        half_pending;

    deconcatenate #(.ERR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_kind      (in_kind),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_pulse    (err_pulse),
        .err_cnt      (err_cnt),
        .half_pending (half_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: what the stream should look like, kept as plain variables.
    bit       m_have_hi;
    int       m_hi;
    bit       m_out_vld;
    int       m_out_dat;
    bit       m_out_tag;
    bit       m_pulse;
    int       m_err_cnt;

    // Values currently driven, used by the model at the next edge.
    bit       d_v;
    bit       d_k;
    int       d_d;
    bit       d_r;

    function automatic logic [19:0] expv();
        logic [7:0] dat;
        logic [7:0] cnt;
        dat = m_out_dat[7:0];
        cnt = m_err_cnt[7:0];
        return {m_out_vld, m_out_tag, dat, m_pulse, m_have_hi, cnt};
    endfunction

    function automatic logic [19:0] obsv();
        return {out_valid, out_tag, out_data, err_pulse, half_pending, err_cnt};
    endfunction

    function automatic bit exp_ready();
        return !m_out_vld || d_r;
    endfunction

    task automatic model_reset();
        m_have_hi = 0; m_hi = 0; m_out_vld = 0; m_out_dat = 0;
        m_out_tag = 0; m_pulse = 0; m_err_cnt = 0;
    endtask

    task automatic drive(input bit v, input bit k, input int d, input bit r);
        @(negedge clk);
        d_v = v; d_k = k; d_d = d & 16'hFFFF; d_r = r;
        in_valid = v; in_kind = k; in_data = d[15:0]; out_ready = r;
        #1;
    endtask

    // Advance one edge and apply the packing rules to the model.
    task automatic tick();
        bit acc;
        bit load;
        int ldat;
        bit ltag;
        bit pulse;
        acc = d_v && (!m_out_vld || d_r);
        load = 0; ldat = 0; ltag = 0; pulse = 0;
        if (acc) begin
            if (!d_k) begin
                if ((d_d & 16'hFFC3) == 16'h0003) begin
                    if (m_have_hi) begin
                        load = 1; ldat = m_hi * 16 + ((d_d >> 2) % 16); m_have_hi = 0;
                    end else begin
                        m_hi = (d_d >> 2) % 16; m_have_hi = 1;
                    end
                end else begin
                    pulse = 1;
                end
            end else begin
                if (d_d == (d_d % 4) * 16'h5555) begin
                    load = 1; ldat = d_d % 4; ltag = 1;
                    if (m_have_hi) begin
                        pulse = 1; m_have_hi = 0;
                    end
                end else begin
                    pulse = 1;
                end
            end
        end
        if (load) begin
            m_out_vld = 1; m_out_dat = ldat; m_out_tag = ltag;
        end else if (m_out_vld && d_r) begin
            m_out_vld = 0; m_out_dat = 0; m_out_tag = 0;
        end
        m_pulse = pulse;
        if (pulse && m_err_cnt < 255) m_err_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 0; in_kind = 0; in_data = 0; out_ready = 1;
        d_v = 0; d_k = 0; d_d = 0; d_r = 1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (obsv() !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obsv(), 20'h0);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_byte_assembly();
        drive(1, 0, 16'h003F, 1); tick();
        n_checks++;
        if (half_pending !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_half: half=%b valid=%b want half=1 valid=0", half_pending, out_valid);
        end
        drive(1, 0, 16'h0017, 1); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF5 || out_tag !== 1'b0 || half_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_out: valid=%b data=%h tag=%b half=%b want 1 f5 0 0",
                     out_valid, out_data, out_tag, half_pending);
        end
        drive(0, 0, 0, 1); tick();
        n_checks++;
        if (obsv() !== expv() || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_drain: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_replicated();
        drive(1, 1, 16'hAAAA, 1); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || out_tag !== 1'b1 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rep_code: valid=%b data=%h tag=%b err=%b want 1 02 1 0",
                     out_valid, out_data, out_tag, err_pulse);
        end
        drive(1, 1, 16'hAAAB, 1); tick();
        n_checks++;
        if (out_valid !== 1'b0 || err_pulse !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rep_bad: valid=%b err=%b cnt=%0d want 0 1 1", out_valid, err_pulse, err_cnt);
        end
        drive(0, 0, 0, 1); tick();
        n_checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rep_pulse_once: err=%b cnt=%0d want 0 1", err_pulse, err_cnt);
        end
    endtask

    task automatic test_bad_framing();
        do_reset();
        drive(1, 0, 16'h0040, 1); tick();
        n_checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || half_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_0040: err=%b cnt=%0d half=%b want 1 1 0", err_pulse, err_cnt, half_pending);
        end
        drive(1, 0, 16'h013F, 1); tick();
        n_checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd2 || half_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_013f: err=%b cnt=%0d half=%b want 1 2 0", err_pulse, err_cnt, half_pending);
        end
        drive(1, 0, 16'h0007, 1); tick();
        drive(1, 0, 16'h002B, 1); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h1A || out_tag !== 1'b0 || err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL frame_recover: valid=%b data=%h tag=%b cnt=%0d want 1 1a 0 2",
                     out_valid, out_data, out_tag, err_cnt);
        end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_orphan();
        do_reset();
        drive(1, 0, 16'h003F, 1); tick();
        drive(1, 1, 16'hFFFF, 1); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_tag !== 1'b1 || err_pulse !== 1'b1 ||
            err_cnt !== 8'd1 || half_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan: valid=%b data=%h tag=%b err=%b cnt=%0d half=%b want 1 03 1 1 1 0",
                     out_valid, out_data, out_tag, err_pulse, err_cnt, half_pending);
        end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_backpressure();
        drive(1, 1, 16'hAAAA, 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 16'h5555, 0);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h02 || out_tag !== 1'b1 || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i, obsv(), expv());
            end
        end
        for (int i = 0; i < 3; i++) begin
            int w;
            w = (i == 0) ? 16'h5555 : (i == 1) ? 16'hFFFF : 16'h0000;
            drive(1, 1, w, 1);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_resume_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'((w % 4)) || obsv() !== expv()) begin
                n_fail++;
                $display("FAIL bp_resume[%0d]: got %h want %h", i, obsv(), expv());
            end
        end
        drive(0, 0, 0, 1); tick();
    endtask

    task automatic test_random();
        bit v;
        bit k;
        int d;
        bit r;
        bit hold;
        do_reset();
        v = 0; k = 0; d = 0; hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                k = $urandom_range(0, 1);
                case ($urandom_range(0, 3))
                    0, 1: d = k ? ($urandom_range(0, 3) * 16'h5555)
                                : (($urandom_range(0, 15) << 2) | 3);
                    2:    d = $urandom_range(0, 65535);
                    default: d = k ? 16'hAAAB : 16'h0040;
                endcase
            end
            r = ($urandom_range(0, 2) != 0);
            drive(v, k, d, r);
            n_checks++;
            if (in_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            hold = v && !exp_ready();
            tick();
            n_checks++;
            if (obsv() !== expv()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 16'h0040, 1); tick();
        end
        n_checks++;
        if (err_cnt !== 8'd255 || err_pulse !== 1'b1 || obsv() !== expv()) begin
            n_fail++;
            $display("FAIL saturate: cnt=%0d err=%b want 255 1", err_cnt, err_pulse);
        end
        drive(0, 0, 0, 1); tick();
        n_checks++;
        if (err_cnt !== 8'd255 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_hold: cnt=%0d err=%b want 255 0", err_cnt, err_pulse);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 16'hAAAA, 0); tick();
        drive(1, 0, 16'h003F, 1); tick();
        n_checks++;
        if (half_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: half=%b want 1", half_pending);
        end
        drive(0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obsv() !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h want %h", obsv(), 20'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 16'h003F, 1); tick();
        drive(1, 0, 16'h0017, 1); tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hF5 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_after: valid=%b data=%h cnt=%0d want 1 f5 0", out_valid, out_data, err_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 0; in_kind = 0; in_data = 0; out_ready = 1;
        test_reset();
        test_byte_assembly();
        test_replicated();
        test_bad_framing();
        test_orphan();
        test_backpressure();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deconcatenate.md
# deconcatenate

Stream unpacker that reverses the team's packing formats. Frame words carry a nibble in `{2'b00, nibble, 2'b11}`. Replicated words carry a 2-bit code as `{8{code}}`. The block accepts 16-bit words over a valid/ready handshake and checks each word's format. It pairs frame nibbles into bytes, extracts replicated codes, and drops malformed words while counting them. It sits on the receive side of any path that uses those packing formats.

## Interface
- `ERR_W`, default 8: width of the saturating error counter.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  16: packed word.
- `in_kind`  in  1: 0 = frame word (low 8 bits meaningful); 1 = replicated word.
- `in_valid`  in  1: `in_data`/`in_kind` valid.
- `in_ready`  out  1: block accepts the word this cycle.
- `out_data`  out  8: assembled byte (tag 0), or `{6'b0, code}` (tag 1).
- `out_tag`  out  1: 0 = byte from two nibbles; 1 = replicated code.
- `out_valid`  out  1: output register holds an item.
- `out_ready`  in  1: downstream consumes the item.
- `err_pulse`  out  1: one-cycle pulse per rejected or discarded event.
- `err_cnt`  out  ERR_W: saturating count of error events.
- `half_pending`  out  1: high nibble stored, waiting for its pair.

## Operation
- **Accept rule:** a word is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
- **Frame word check (kind 0):**
  - Valid iff `in_data[15:8]==0`, `in_data[7:6]==2'b00` and `in_data[1:0]==2'b11`.
  - Nibble = `in_data[5:2]`.
- **Replicated word check (kind 1):**
  - Valid iff all eight 2-bit slices equal `in_data[1:0]`.
  - Code = `in_data[1:0]`.
- **State machine:** two states, EMPTY and HALF. `half_pending` = (state==HALF).
  - EMPTY + valid frame: store nibble as high nibble, go to HALF. No output.
  - HALF + valid frame: load `out_data = {hi, nibble}`, `out_tag=0`, `out_valid=1`. Go to EMPTY.
  - Any state + valid replicated word: load `out_data = {6'b0, code}`, `out_tag=1`, `out_valid=1`.
    - If in HALF: also discard the stored nibble, raise `err_pulse`, increment `err_cnt`, go to EMPTY.
  - Any state + malformed word: drop the word, raise `err_pulse`, increment `err_cnt`. State unchanged.
- **Error counter:**
  - Increments by exactly 1 per accepted word that raises `err_pulse`.
  - Saturates at 2^ERR_W−1 and never wraps.
- **Output register:**
  - Cleared when `out_valid && out_ready` and no new load happens that cycle.
  - A load and a consume in the same cycle replace the contents; `out_valid` stays 1.
  - `out_data`/`out_tag` hold their values while `out_valid && !out_ready`.
- **Reset values** (any time, including mid-operation):
  - state EMPTY, stored nibble 0.
  - `out_valid=0`, `out_data=0`, `out_tag=0`.
  - `err_pulse=0`, `err_cnt=0`.

## Timing
- Latency: the word that completes an item is accepted at edge N; `out_valid` is high after edge N.
- Throughput: one word per cycle while `out_ready` is held high, i.e. one byte per 2 frame words, or one code per replicated word.
- `err_pulse` is registered and asserted for exactly the cycle after the offending word is accepted.
- Backpressure: with `out_valid=1` and `out_ready=0`:
  - `in_ready=0`, so no word is accepted, including malformed ones.
  - State, stored nibble and counter are frozen.
- `in_valid` without `in_ready` has no effect. The source must hold its word until accepted.
- Reset deassertion: the block can accept a word on the first rising edge after `rst` falls.

## Test plan
- **Byte assembly:** kind 0 `0x003F` then kind 0 `0x0017`, `out_ready=1` → one output `out_data=0xF5`, `out_tag=0`, one cycle after the second accept. `half_pending` is 1 between the two words.
- **Replicated code:** kind 1 `0xAAAA` → `out_data=0x02`, `out_tag=1`. Kind 1 `0xAAAB` → no output, `err_pulse` once, `err_cnt=1`.
- **Bad framing:**
  - kind 0 `0x0040` → dropped, error counted.
  - kind 0 `0x013F` (nonzero upper byte) → dropped, error counted.
  - A following valid pair still assembles correctly.
- **Orphan nibble:** kind 0 `0x003F`, then kind 1 `0xFFFF` → `out_data=0x03`, `out_tag=1`, `err_pulse`, `err_cnt=1`, `half_pending=0`.
- **Backpressure:**
  - Setup: hold `out_ready=0` after one output. Stimulus: keep `in_valid=1` for 5 cycles.
  - Required: `in_ready=0` and the output is stable throughout.
  - Then raise `out_ready` → transfers resume, with simultaneous consume and load every cycle.
- **Saturation and reset:**
  - 300 malformed words → `err_cnt=255`, no wrap.
  - Assert `rst` mid-byte (in HALF) → all outputs 0, `half_pending=0` asynchronously.
